// File: rtl/athena_ioctl_loader.sv
// athena_ioctl_loader: source side of the hps_io ROM download port.
// Accepts a (base, length) start command, pulls bytes from a valid/ready
// stream and emits paced single-cycle ioctl_wr strobes at incrementing
// addresses. WR_GAP idle clocks follow every strobe so that sinks clocked
// by slow clock enables still capture each byte.
//
// Optional build macro: ATHENA_IOCTL_LOADER_CSUM_EN adds a 16-bit additive
// checksum output (csum) of all bytes written in the current transfer.
//
// state  | meaning
// IDLE   | waiting for start; address/data hold their last values
// FETCH  | s_ready high, waiting for a stream byte
// WRITE  | one-cycle ioctl_wr strobe
// GAP    | pacing countdown; address advances on its last cycle
// FINISH | one-cycle done pulse

module athena_ioctl_loader #(
  parameter int WR_GAP = 8,
  parameter int LEN_W  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [24:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [24:0]      ioctl_addr,
  output logic [7:0]       ioctl_data,
  output logic             ioctl_wr,
  output logic             ioctl_download,
  output logic             busy,
  output logic             done
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
  ,
  output logic [15:0]      csum
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [7:0]       GAP_LOAD  = 8'(WR_GAP - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO  = '0;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [24:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [7:0]       gap_q, gap_d;
  logic             dl_q, dl_d;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
  logic [15:0]      csum_q, csum_d;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      remain_q <= '0;
      gap_q    <= '0;
      dl_q     <= 1'b0;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      remain_q <= remain_d;
      gap_q    <= gap_d;
      dl_q     <= dl_d;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == LEN_ZERO) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (s_valid) state_d = WRITE;
      end
      WRITE: state_d = GAP;
      GAP: begin
        if (gap_q == 8'd0) begin
          // remain_q still holds the pre-decrement count here
          state_d = (remain_q == LEN_ONE) ? FINISH : FETCH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: address, data, remaining count, pacing counter.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    remain_d = remain_q;
    gap_d    = gap_q;
    dl_d     = dl_q;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = length;
          dl_d     = (length != LEN_ZERO);
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
          csum_d   = '0;
`endif
        end
      end
      FETCH: begin
        if (s_valid) data_d = s_data;
      end
      WRITE: begin
        gap_d  = GAP_LOAD;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
        csum_d = csum_q + {8'h00, data_q};
`endif
      end
      GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          addr_d   = addr_q + 25'd1;
          remain_d = remain_q - LEN_ONE;
          // download must already be low in the FINISH cycle
          if (remain_q == LEN_ONE) dl_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    s_ready  = (state_q == FETCH);
    ioctl_wr = (state_q == WRITE);
    done     = (state_q == FINISH);
    busy     = (state_q != IDLE);
  end

  assign ioctl_addr     = addr_q;
  assign ioctl_data     = data_q;
  assign ioctl_download = dl_q;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
  assign csum           = csum_q;
`endif

endmodule

// File: tb/tb_athena_ioctl_loader.sv
// Self-checking bench for athena_ioctl_loader. A transaction-level model
// predicts, from the stream-valid pattern, the cycle, address and data of
// every strobe, the done cycle, the download window and the checksum.
module tb_athena_ioctl_loader;

  localparam int WR_GAP = 8;
  localparam int LEN_W  = 20;
  localparam int VPN    = 65536;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [24:0]      base_addr;
  logic [LEN_W-1:0] length;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_data;
  logic             ioctl_wr;
  logic             ioctl_download;
  logic             busy;
  logic             done;
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
  logic [15:0]      csum;
`endif

  athena_ioctl_loader #(.WR_GAP(WR_GAP), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_download (ioctl_download),
    .busy           (busy),
    .done           (done)
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
    ,
    .csum           (csum)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bit          vp[VPN];
  logic [7:0]  src_bytes[$];
  int          src_idx = 0;

  int          obs_cyc[$];
  logic [24:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  int          done_cyc[$];
  int          dl_cnt, dl_first;

  int          stall_lo = -1, stall_hi = -1, stall_bad = 0;
  logic [24:0] stall_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs at negedge, then drive inputs 1ns after posedge.
  task automatic tick();
    @(negedge clk);
    if (ioctl_wr) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(ioctl_addr);
      obs_data.push_back(ioctl_data);
    end
    if (done) done_cyc.push_back(cyc);
    if (ioctl_download) begin
      if (dl_cnt == 0) dl_first = cyc;
      dl_cnt++;
    end
    if (cyc >= stall_lo && cyc <= stall_hi) begin
      if (!s_ready || ioctl_wr || ioctl_addr !== stall_addr) stall_bad++;
    end
    if (s_valid && s_ready) src_idx++;
    @(posedge clk);
    cyc++;
    #1;
    start = 1'b0;
    if (src_idx < src_bytes.size() && vp[cyc % VPN]) begin
      s_valid = 1'b1;
      s_data  = src_bytes[src_idx];
    end else begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
  endtask

  task automatic fill_vp(input int dens);
    for (int c = cyc; c < cyc + 3000; c++) vp[c % VPN] = ($urandom_range(99, 0) < dens);
  endtask

  task automatic fill_src(input int n);
    src_bytes.delete();
    for (int i = 0; i < n; i++) src_bytes.push_back(8'($urandom));
  endtask

  // Runs one transfer of src_bytes and checks it against the model.
  task automatic run_xfer(input string nm, input logic [24:0] base, input int inj_off);
    int          len;
    int          k0, e, c, exp_done, nchk;
    int          exp_wc[$];
    logic [15:0] sum;
    len = src_bytes.size();
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete(); done_cyc.delete();
    dl_cnt = 0; dl_first = -1; src_idx = 0;
    // model: byte k is taken on the first valid cycle at or after the
    // FETCH opportunity, strobes one cycle later, next FETCH WR_GAP+1 after that
    k0 = cyc; e = k0 + 1; sum = '0;
    for (int k = 0; k < len; k++) begin
      c = e;
      while (!vp[c % VPN] && c < e + 3000) c++;
      exp_wc.push_back(c + 1);
      e = c + WR_GAP + 2;
      sum = sum + {8'h00, src_bytes[k]};
    end
    exp_done = (len > 0) ? exp_wc[len-1] + WR_GAP + 1 : k0 + 1;

    base_addr = base;
    length    = LEN_W'(len);
    start     = 1'b1;
    tick();
    while (done_cyc.size() == 0 && cyc < k0 + 4000) begin
      if (inj_off > 0 && cyc == k0 + inj_off) begin
        start     = 1'b1;
        base_addr = 25'($urandom);
        length    = LEN_W'($urandom_range(9, 1));
      end
      tick();
    end
    chk({nm, "_done_seen"}, 32'(done_cyc.size() > 0), 32'(1));
    tick();
    tick();

    chk({nm, "_wr_count"}, 32'(obs_cyc.size()), 32'(len));
    nchk = (obs_cyc.size() < len) ? obs_cyc.size() : len;
    for (int k = 0; k < nchk; k++) begin
      chk({nm, "_wr_cyc"},  32'(obs_cyc[k] - k0), 32'(exp_wc[k] - k0));
      chk({nm, "_wr_addr"}, 32'(obs_addr[k]),     32'(25'(base + 25'(k))));
      chk({nm, "_wr_data"}, 32'(obs_data[k]),     32'(src_bytes[k]));
    end
    chk({nm, "_done_count"}, 32'(done_cyc.size()), 32'(1));
    if (done_cyc.size() > 0) chk({nm, "_done_cyc"}, 32'(done_cyc[0] - k0), 32'(exp_done - k0));
    chk({nm, "_dl_cycles"}, 32'(dl_cnt), 32'((len > 0) ? exp_done - k0 - 1 : 0));
    if (len > 0) chk({nm, "_dl_first"}, 32'(dl_first - k0), 32'(1));
    chk({nm, "_busy_after"}, 32'(busy), 32'(0));
    chk({nm, "_addr_hold"}, 32'(ioctl_addr), 32'(25'(base + 25'(len))));
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
    chk({nm, "_csum"}, 32'(csum), 32'(sum));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] b;
    int          k0;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < VPN; i++) vp[i] = 1'b0;
    repeat (3) tick();
    chk("rst_addr",     32'(ioctl_addr),     32'(0));
    chk("rst_data",     32'(ioctl_data),     32'(0));
    chk("rst_wr",       32'(ioctl_wr),       32'(0));
    chk("rst_download", 32'(ioctl_download), 32'(0));
    chk("rst_busy",     32'(busy),           32'(0));
    chk("rst_done",     32'(done),           32'(0));
    chk("rst_ready",    32'(s_ready),        32'(0));
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
    chk("rst_csum",     32'(csum),           32'(0));
`endif
    reset = 1'b0;
    tick();

    // basic transfer, always valid
    src_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_vp(100);
    run_xfer("basic", 25'h0000100, 0);
    if (obs_cyc.size() >= 2) chk("basic_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'(WR_GAP + 2));
`ifdef ATHENA_IOCTL_LOADER_CSUM_EN
    chk("basic_csum_aa", 32'(csum), 32'h00AA);
`endif

    // zero length
    src_bytes.delete();
    fill_vp(100);
    run_xfer("zero", 25'h0012345, 0);

    // backpressure: 20 invalid cycles while waiting for byte 2
    fill_src(4);
    fill_vp(100);
    k0 = cyc;
    for (int c = k0 + 11; c <= k0 + 30; c++) vp[c % VPN] = 1'b0;
    stall_lo = k0 + 11; stall_hi = k0 + 30; stall_addr = 25'h0000A01; stall_bad = 0;
    run_xfer("bp", 25'h0000A00, 0);
    chk("bp_stall_ok", 32'(stall_bad), 32'(0));
    stall_lo = -1; stall_hi = -1;

    // address wrap
    fill_src(3);
    fill_vp(100);
    run_xfer("wrap", 25'h1FFFFFE, 0);

    // start during GAP is ignored
    fill_src(3);
    fill_vp(100);
    run_xfer("ignore", 25'h0004000, 4);

    // reset mid-transfer, with a simultaneous start
    fill_src(5);
    fill_vp(100);
    src_idx = 0;
    base_addr = 25'h0007700; length = LEN_W'(5); start = 1'b1;
    tick();
    repeat (6) tick();
    done_cyc.delete();
    reset = 1'b1; start = 1'b1; base_addr = 25'h0001111; length = LEN_W'(3);
    tick();
    chk("abort_addr",     32'(ioctl_addr),     32'(0));
    chk("abort_data",     32'(ioctl_data),     32'(0));
    chk("abort_wr",       32'(ioctl_wr),       32'(0));
    chk("abort_download", 32'(ioctl_download), 32'(0));
    chk("abort_busy",     32'(busy),           32'(0));
    chk("abort_ready",    32'(s_ready),        32'(0));
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cyc.size()), 32'(0));
    chk("abort_idle",    32'(busy),            32'(0));

    // fresh start after reset
    fill_src(2);
    fill_vp(100);
    run_xfer("after_rst", 25'h0003300, 0);

    // randomized transfers with random stream valid density
    for (int t = 0; t < 10; t++) begin
      fill_src($urandom_range(6, 0));
      fill_vp($urandom_range(100, 20));
      b = ($urandom_range(3, 0) == 0) ? 25'h1FFFFFC + 25'($urandom_range(3, 0)) : 25'($urandom);
      run_xfer("rand", b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
